// File: rtl/frame_capture_writer.sv
// frame_capture_writer: streams audio samples into a two-bank (ping-pong) RAM.
// Each bank holds 2**(ADDR_WIDTH-1) words and is addressed as {bank, offset}.
// When a bank is filled, frame_ready pulses and the writer moves to the other bank.
// If that bank has not been released with frame_ack yet, the writer stalls and drops samples.
// Optional feature: define FRAME_CAPTURE_DROP_CNT_EN to build the 16-bit saturating
// dropped-sample counter. Without it, drop_cnt is tied to zero.
module frame_capture_writer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  capture_en,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  frame_ack,
  input  logic                  frame_ack_bank,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_ready,
  output logic                  frame_bank,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  localparam int OFF_W = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

  state_t           state, state_next;
  logic             cur_bank, cur_bank_next;
  logic [OFF_W-1:0] offset, offset_next;
  logic [1:0]       full, full_next;
  logic [1:0]       full_acked;
  logic             accept, last_word, drop;

  // Bank status after this cycle's ack. The ack is applied before the end-of-bank check,
  // so a release of the other bank in the same cycle avoids a stall.
  always_comb begin
    full_acked = full;
    if (frame_ack && !(state == FILL && frame_ack_bank == cur_bank))
      full_acked[frame_ack_bank] = 1'b0;
  end

  // Next-state logic, bank/offset sequencing and sample accept/drop decisions.
  always_comb begin
    state_next    = state;
    cur_bank_next = cur_bank;
    offset_next   = offset;
    full_next     = full_acked;
    accept        = 1'b0;
    last_word     = 1'b0;
    drop          = 1'b0;
    case (state)
      IDLE: begin
        if (capture_en) begin
          state_next  = FILL;
          offset_next = '0;
        end
      end
      FILL: begin
        if (!capture_en) begin
          state_next  = IDLE;
          offset_next = '0;
        end else if (sample_valid) begin
          accept = 1'b1;
          if (offset == {OFF_W{1'b1}}) begin
            last_word           = 1'b1;
            full_next[cur_bank] = 1'b1;
            cur_bank_next       = ~cur_bank;
            offset_next         = '0;
            if (full_acked[~cur_bank])
              state_next = STALL;
          end else begin
            offset_next = offset + 1'b1;
          end
        end
      end
      STALL: begin
        drop = sample_valid;
        if (!capture_en) begin
          state_next  = IDLE;
          offset_next = '0;
        end else if (!full_acked[cur_bank]) begin
          state_next  = FILL;
          offset_next = '0;
        end
      end
      default: begin
        state_next  = IDLE;
        offset_next = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state    <= IDLE;
      cur_bank <= 1'b0;
      offset   <= '0;
      full     <= 2'b00;
    end else begin
      state    <= state_next;
      cur_bank <= cur_bank_next;
      offset   <= offset_next;
      full     <= full_next;
    end
  end

  // Registered RAM write port and frame status outputs. Address and data hold when idle.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_ready <= 1'b0;
      frame_bank  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_en       <= accept;
      frame_ready <= last_word;
      if (accept) begin
        wr_addr <= {cur_bank, offset};
        wr_data <= sample_in;
      end
      if (last_word)
        frame_bank <= cur_bank;
      if (drop)
        overflow <= 1'b1;
    end
  end

`ifdef FRAME_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_count;

  // Saturating count of samples dropped while stalled.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst)
      drop_count <= 16'h0000;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end

  assign drop_cnt = drop_count;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_capture_writer.sv
// tb_frame_capture_writer: directed test of frame_capture_writer.
// It uses a sample-level model that tracks the linear write position, the bank-full flags
// and the stall condition. One compare process checks every output on every negedge.
// Literal checks pin the key addresses, pulses and counts.
module tb_frame_capture_writer;

`ifdef FRAME_CAPTURE_DROP_CNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_en, sample_valid, frame_ack, frame_ack_bank;
  logic [15:0] sample_in;
  logic        wr_en, frame_ready, frame_bank, overflow;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] drop_cnt;

  frame_capture_writer dut (
    .wr_clk(clk), .wr_rst(rst), .capture_en(capture_en), .sample_in(sample_in),
    .sample_valid(sample_valid), .frame_ack(frame_ack), .frame_ack_bank(frame_ack_bank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_ready(frame_ready),
    .frame_bank(frame_bank), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int fr_count = 0;
  bit check_en = 1'b0;

  // Model state. m_pos is the linear write position 0..2047, and bank = m_pos / 1024.
  bit     m_cap, m_stall, m_ovf;
  bit [1:0] m_full;
  int     m_pos, m_drop;
  // Expected outputs for the coming edge (n_*) and the current cycle (e_*).
  bit     n_we, n_fr, n_fb, e_we, e_fr, e_fb, e_ovf;
  int     n_addr, n_data, e_addr, e_data, e_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_stall = 0; m_ovf = 0; m_full = 2'b00; m_pos = 0; m_drop = 0;
    n_we = 0; n_fr = 0; n_fb = 0; n_addr = 0; n_data = 0;
    e_we = 0; e_fr = 0; e_fb = 0; e_ovf = 0; e_addr = 0; e_data = 0; e_drop = 0;
  endtask

  // Applies the behavioural rules for one cycle of inputs.
  task automatic model_step(input logic cap, input logic v, input logic [15:0] d,
                            input logic ack, input logic ab);
    int bank;
    bank = m_pos / 1024;
    n_we = 0;
    n_fr = 0;
    if (m_cap && m_stall && v) begin
      m_ovf = 1;
      if (DROP_ON == 1 && m_drop < 65535) m_drop++;
    end
    if (ack && !(m_cap && !m_stall && int'(ab) == bank)) m_full[ab] = 1'b0;
    if (!m_cap) begin
      if (cap) begin m_cap = 1; m_stall = 0; end
    end else if (!cap) begin
      m_cap = 0; m_stall = 0; m_pos = bank * 1024;
    end else if (m_stall) begin
      if (!m_full[bank]) m_stall = 0;
    end else if (v) begin
      n_we = 1; n_addr = m_pos; n_data = int'(d);
      if (m_pos % 1024 == 1023) begin
        n_fr = 1; n_fb = bank[0]; m_full[bank] = 1'b1;
        m_pos = (m_pos + 1) % 2048;
        if (m_full[m_pos / 1024]) m_stall = 1;
      end else begin
        m_pos++;
      end
    end
  endtask

  // Drive one cycle of inputs, step the model, then advance past the clock edge.
  task automatic cycle(input logic cap, input logic v, input logic [15:0] d,
                       input logic ack = 1'b0, input logic ab = 1'b0);
    capture_en = cap; sample_valid = v; sample_in = d; frame_ack = ack; frame_ack_bank = ab;
    model_step(cap, v, d, ack, ab);
    @(posedge clk);
    e_we = n_we; e_fr = n_fr;
    if (n_we) begin e_addr = n_addr; e_data = n_data; end
    if (n_fr) e_fb = n_fb;
    e_ovf = m_ovf; e_drop = m_drop;
    #1;
  endtask

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (check_en && !rst) begin
      check("wr_en", 32'(wr_en), 32'(e_we));
      check("wr_addr", 32'(wr_addr), 32'(e_addr));
      check("wr_data", 32'(wr_data), 32'(e_data));
      check("frame_ready", 32'(frame_ready), 32'(e_fr));
      check("frame_bank", 32'(frame_bank), 32'(e_fb));
      check("overflow", 32'(overflow), 32'(e_ovf));
      check("drop_cnt", 32'(drop_cnt), 32'(e_drop));
      if (frame_ready) fr_count++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; capture_en = 0; sample_valid = 0; sample_in = 0; frame_ack = 0; frame_ack_bank = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    check_en = 1'b1;

    // First frame into bank 0: samples 0..1023.
    cycle(1, 0, 16'd0);
    for (int i = 0; i < 1024; i++) cycle(1, 1, 16'(i));
    check("frame0_addr", 32'(wr_addr), 32'd1023);
    check("frame0_data", 32'(wr_data), 32'd1023);
    check("frame0_ready", 32'(frame_ready), 32'd1);
    check("frame0_bank", 32'(frame_bank), 32'd0);
    check("frame0_count", 32'(fr_count), 32'd0);
    // Second frame into bank 1 with no ack. The writer then stalls and drops 5 samples.
    for (int i = 0; i < 1024; i++) cycle(1, 1, 16'(1024 + i));
    check("frame1_addr", 32'(wr_addr), 32'd2047);
    check("frame1_ready", 32'(frame_ready), 32'd1);
    check("frame1_bank", 32'(frame_bank), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 16'hDEAD);
    check("stall_wr_en", 32'(wr_en), 32'd0);
    check("stall_overflow", 32'(overflow), 32'd1);
    check("stall_drop_cnt", 32'(drop_cnt), 32'(5 * DROP_ON));
    check("frame_count_2", 32'(fr_count), 32'd2);

    // Releasing bank 0 resumes capture at address 0.
    cycle(1, 0, 16'd0, 1, 0);
    cycle(1, 1, 16'hAAAA);
    check("resume_addr", 32'(wr_addr), 32'd0);
    check("resume_data", 32'(wr_data), 32'hAAAA);
    // Last write of bank 0 coincides with an ack of bank 1, so there is no stall.
    for (int i = 1; i < 1023; i++) cycle(1, 1, 16'(i));
    cycle(1, 1, 16'h7777, 1, 1);
    check("simul_addr", 32'(wr_addr), 32'd1023);
    check("simul_ready", 32'(frame_ready), 32'd1);
    cycle(1, 1, 16'h5555);
    check("simul_next_addr", 32'(wr_addr), 32'd1024);
    check("simul_next_en", 32'(wr_en), 32'd1);

    // Abort after 300 samples in bank 1. Samples in IDLE are ignored.
    for (int i = 1; i < 300; i++) cycle(1, 1, 16'(i));
    check("abort_last_addr", 32'(wr_addr), 32'd1323);
    cycle(0, 0, 16'd0);
    cycle(0, 1, 16'hBEEF);
    cycle(0, 1, 16'hBEEF);
    cycle(1, 1, 16'hBEEF);
    cycle(1, 1, 16'h0300);
    check("abort_restart_addr", 32'(wr_addr), 32'd1024);
    check("abort_restart_data", 32'(wr_data), 32'h0300);
    check("abort_frame_count", 32'(fr_count), 32'd3);

    // Asynchronous reset at offset 500 of bank 1.
    for (int i = 1; i < 500; i++) cycle(1, 1, 16'(i));
    #2;
    check_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_wr_en", 32'(wr_en), 32'd0);
    check("async_wr_addr", 32'(wr_addr), 32'd0);
    check("async_wr_data", 32'(wr_data), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_drop_cnt", 32'(drop_cnt), 32'd0);
    sample_valid = 0; capture_en = 0; frame_ack = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_en = 1'b1;
    cycle(1, 0, 16'd0);
    cycle(1, 1, 16'h1234);
    check("post_reset_addr", 32'(wr_addr), 32'd0);
    check("post_reset_data", 32'(wr_data), 32'h1234);

    // Ignored acks: bank 1 is not full, and bank 0 is currently being filled.
    for (int i = 1; i < 1024; i++) cycle(1, 1, 16'(i), (i == 100 || i == 200), (i == 100));
    for (int i = 0; i < 1024; i++) cycle(1, 1, 16'(i));
    cycle(1, 1, 16'hCAFE);
    cycle(1, 1, 16'hCAFE);
    check("ign_ack_wr_en", 32'(wr_en), 32'd0);
    check("ign_ack_overflow", 32'(overflow), 32'd1);
    check("ign_ack_drop", 32'(drop_cnt), 32'(2 * DROP_ON));
    // Releasing the other bank while stalled does not resume capture.
    cycle(1, 0, 16'd0, 1, 1);
    cycle(1, 1, 16'hCAFE);
    check("other_ack_wr_en", 32'(wr_en), 32'd0);
    check("other_ack_drop", 32'(drop_cnt), 32'(3 * DROP_ON));
    cycle(1, 0, 16'd0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
